// File: rtl/rfblackwidow_icache_refill_pkg.sv
// Shared constants and types for the BlackWidow instruction-cache refill path.
package rfblackwidow_icache_refill_pkg;

   localparam int ICACHE_AWID    = 32;
   localparam int ICACHE_LINES   = 128;
   localparam int ICACHE_WAYS    = 4;
   localparam int ICACHE_BEATS   = 8;
   localparam int ICACHE_BUS_DW  = 128;
   localparam int ICACHE_SET_LSB = 7;
   localparam int ICACHE_SET_MSB = 13;

   typedef enum logic [1:0] {
      IC_IDLE   = 2'd0,
      IC_FETCH  = 2'd1,
      IC_FINISH = 2'd2
   } icrefill_state_t;

endpackage

// File: rtl/rfblackwidow_icache_refill_if.sv
// Refill bus: the refill controller is the master, the memory side the slave.
interface rfblackwidow_icache_refill_if
   import rfblackwidow_icache_refill_pkg::*;
   #(parameter int AWID = ICACHE_AWID);

   logic                     bus_req;
   logic [AWID-1:0]          bus_adr;
   logic                     bus_ack;
   logic                     bus_err;
   logic [ICACHE_BUS_DW-1:0] bus_dat;

   modport master (output bus_req, bus_adr, input bus_ack, bus_err, bus_dat);
   modport slave  (input bus_req, bus_adr, output bus_ack, bus_err, bus_dat);

endinterface

// File: rtl/rfblackwidow_icache_refill_victim.sv
// Victim way selection: lowest invalid way at the set, else the round-robin way.
module rfblackwidow_icache_refill_victim
   import rfblackwidow_icache_refill_pkg::*;
(
   input  logic [ICACHE_WAYS-1:0] set_valid,
   input  logic [1:0]             rr_ptr,
   output logic [1:0]             victim
);

   logic found_s;

   // Scan ways upward so the lowest free way is taken first.
   always_comb begin
      victim  = rr_ptr;
      found_s = 1'b0;
      for (int i = 0; i < ICACHE_WAYS; i++) begin
         if (!found_s && !set_valid[i]) begin
            victim  = 2'(i);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/rfblackwidow_icache_refill.sv
// I-cache refill controller: victim choice, 8-beat line fill, tag write and
// ownership of the per-way line valid bits including invalidation.
module rfblackwidow_icache_refill
   import rfblackwidow_icache_refill_pkg::*;
#(
   parameter int AWID  = ICACHE_AWID,
   parameter int LINES = ICACHE_LINES,
   parameter int WAYS  = ICACHE_WAYS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        miss_req,
   input  logic [AWID-1:0]             miss_adr,
   input  logic                        invall,
   input  logic                        invline,
   input  logic [AWID-1:0]             inv_adr,
   input  logic                        inv_hit,
   input  logic [1:0]                  inv_way,
   rfblackwidow_icache_refill_if.master bus,
   output logic                        dwr,
   output logic [1:0]                  dway,
   output logic [6:0]                  dndx,
   output logic [2:0]                  dbeat,
   output logic [ICACHE_BUS_DW-1:0]    ddat,
   output logic                        twr,
   output logic [AWID-8:0]             ttag,
   output logic [WAYS-1:0][LINES-1:0]  valid,
   output logic                        busy,
   output logic                        done,
   output logic                        fault
);

   icrefill_state_t            state_q, state_d;
   logic [2:0]                 beat_q, beat_d;
   logic [1:0]                 rr_q, rr_d;
   logic                       stale_q, stale_d;
   logic [WAYS-1:0][LINES-1:0] valid_q, valid_d;
   logic                       bus_req_q, bus_req_d;
   logic [AWID-1:0]            bus_adr_q, bus_adr_d;
   logic                       dwr_q, dwr_d;
   logic [1:0]                 dway_q, dway_d;
   logic [6:0]                 dndx_q, dndx_d;
   logic [2:0]                 dbeat_q, dbeat_d;
   logic [ICACHE_BUS_DW-1:0]   ddat_q, ddat_d;
   logic                       twr_q, twr_d;
   logic [AWID-8:0]            ttag_q, ttag_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       fault_q, fault_d;

   logic [6:0]                 miss_set_s;
   logic [6:0]                 inv_set_s;
   logic [ICACHE_WAYS-1:0]     set_valid_s;
   logic [1:0]                 victim_s;
   logic                       unused_s;

   assign miss_set_s = miss_adr[ICACHE_SET_MSB:ICACHE_SET_LSB];
   assign inv_set_s  = inv_adr[ICACHE_SET_MSB:ICACHE_SET_LSB];
   assign unused_s   = ^{miss_adr[ICACHE_SET_LSB-1:0], inv_adr[AWID-1:ICACHE_SET_MSB+1],
                         inv_adr[ICACHE_SET_LSB-1:0]};

   // Gather the valid bits of every way at the missing set.
   always_comb begin
      set_valid_s = '0;
      for (int w = 0; w < ICACHE_WAYS; w++) begin
         set_valid_s[w] = valid_q[w][miss_set_s];
      end
   end

   rfblackwidow_icache_refill_victim u_victim (
      .set_valid (set_valid_s),
      .rr_ptr    (rr_q),
      .victim    (victim_s)
   );

   // Next-state and next-output computation for the refill sequence.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      rr_d      = rr_q;
      stale_d   = stale_q;
      valid_d   = valid_q;
      bus_req_d = 1'b0;
      bus_adr_d = bus_adr_q;
      dwr_d     = 1'b0;
      dway_d    = dway_q;
      dndx_d    = dndx_q;
      dbeat_d   = dbeat_q;
      ddat_d    = ddat_q;
      twr_d     = 1'b0;
      ttag_d    = ttag_q;
      done_d    = 1'b0;
      fault_d   = 1'b0;

      case (state_q)
         IC_IDLE: begin
            if (miss_req) begin
               ttag_d                       = miss_adr[AWID-1:ICACHE_SET_LSB];
               dndx_d                       = miss_set_s;
               dway_d                       = victim_s;
               valid_d[victim_s][miss_set_s] = 1'b0;
               beat_d                       = 3'd0;
               stale_d                      = 1'b0;
               bus_req_d                    = 1'b1;
               bus_adr_d                    = {miss_adr[AWID-1:ICACHE_SET_LSB], 3'd0, 4'h0};
               state_d                      = IC_FETCH;
            end else begin
               state_d = IC_IDLE;
            end
         end
         IC_FETCH: begin
            if (bus.bus_err) begin
               fault_d = 1'b1;
               state_d = IC_IDLE;
            end else if (bus.bus_ack) begin
               dwr_d   = 1'b1;
               dbeat_d = beat_q;
               ddat_d  = bus.bus_dat;
               beat_d  = beat_q + 3'd1;
               if (beat_q == 3'(ICACHE_BEATS - 1)) begin
                  state_d = IC_FINISH;
               end else begin
                  bus_req_d = 1'b1;
                  bus_adr_d = {ttag_q, beat_d, 4'h0};
               end
            end else begin
               bus_req_d = 1'b1;
            end
         end
         IC_FINISH: begin
            twr_d  = 1'b1;
            done_d = 1'b1;
            if (!stale_q) begin
               valid_d[dway_q][dndx_q] = 1'b1;
            end else begin
               valid_d[dway_q][dndx_q] = valid_q[dway_q][dndx_q];
            end
            rr_d    = rr_q + 2'd1;
            state_d = IC_IDLE;
         end
         default: begin
            state_d = IC_IDLE;
         end
      endcase

      // An invalidation touching the fill set poisons the line being fetched.
      if (invall || (invline && inv_hit && (inv_set_s == dndx_d))) begin
         stale_d = 1'b1;
      end else begin
         stale_d = stale_d;
      end

      // Invalidations are applied last so they beat a same-cycle line install.
      if (invline && inv_hit) begin
         valid_d[inv_way][inv_set_s] = 1'b0;
      end else begin
         valid_d = valid_d;
      end
      if (invall) begin
         valid_d = '0;
      end else begin
         valid_d = valid_d;
      end

      busy_d = (state_d != IC_IDLE);
   end

   // State and registered-output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IC_IDLE;
         beat_q    <= 3'd0;
         rr_q      <= 2'd0;
         stale_q   <= 1'b0;
         valid_q   <= '0;
         bus_req_q <= 1'b0;
         bus_adr_q <= '0;
         dwr_q     <= 1'b0;
         dway_q    <= 2'd0;
         dndx_q    <= 7'd0;
         dbeat_q   <= 3'd0;
         ddat_q    <= '0;
         twr_q     <= 1'b0;
         ttag_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         rr_q      <= rr_d;
         stale_q   <= stale_d;
         valid_q   <= valid_d;
         bus_req_q <= bus_req_d;
         bus_adr_q <= bus_adr_d;
         dwr_q     <= dwr_d;
         dway_q    <= dway_d;
         dndx_q    <= dndx_d;
         dbeat_q   <= dbeat_d;
         ddat_q    <= ddat_d;
         twr_q     <= twr_d;
         ttag_q    <= ttag_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fault_q   <= fault_d;
      end
   end

   assign bus.bus_req = bus_req_q;
   assign bus.bus_adr = bus_adr_q;
   assign dwr         = dwr_q;
   assign dway        = dway_q;
   assign dndx        = dndx_q;
   assign dbeat       = dbeat_q;
   assign ddat        = ddat_q;
   assign twr         = twr_q;
   assign ttag        = ttag_q;
   assign valid       = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign fault       = fault_q;

endmodule
